// File: rtl/alu_mc.sv
// Multi-cycle ALU with a valid/ready request port and a registered, held result.
// Define ALU_MC_MUL_EN to add the iterative shift-add multiplier (opcode 1010).
module alu_mc #(
    parameter int D_WIDTH = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_op,
    input  logic [D_WIDTH-1:0] a,
    input  logic [D_WIDTH-1:0] b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] y,
    output logic               zero,
    output logic               neg,
    output logic               carry,
    output logic               ovf,
    output logic               illegal
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
`ifdef ALU_MC_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1010;
`endif
    localparam int MSB = D_WIDTH - 1;

    logic [D_WIDTH:0]   add_ext;
    logic [D_WIDTH:0]   sub_ext;
    logic [SHAMT_W-1:0] shamt;
    logic [D_WIDTH-1:0] alu_y;
    logic               alu_c;
    logic               alu_v;
    logic               alu_ill;
    logic               accept;
    logic               out_free;
    logic               wr_en;
    logic [D_WIDTH-1:0] wr_y;
    logic               wr_c;
    logic               wr_v;
    logic               wr_ill;

    assign shamt    = b[SHAMT_W-1:0];
    assign out_free = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath, evaluated straight from the request inputs
    always_comb begin
        add_ext = {1'b0, a} + {1'b0, b};
        sub_ext = {1'b0, a} + {1'b0, ~b} + {{D_WIDTH{1'b0}}, 1'b1};
        alu_y   = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_y = add_ext[D_WIDTH-1:0];
                alu_c = add_ext[D_WIDTH];
                alu_v = (a[MSB] == b[MSB]) && (add_ext[MSB] != a[MSB]);
            end
            OP_SUB: begin
                alu_y = sub_ext[D_WIDTH-1:0];
                alu_c = sub_ext[D_WIDTH];
                alu_v = (a[MSB] != b[MSB]) && (sub_ext[MSB] != a[MSB]);
            end
            OP_AND:  alu_y = a & b;
            OP_OR:   alu_y = a | b;
            OP_XOR:  alu_y = a ^ b;
            OP_SLT:  alu_y = {{(D_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_y = {{(D_WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  alu_y = a << shamt;
            OP_SRL:  alu_y = a >> shamt;
            OP_SRA:  alu_y = $signed(a) >>> shamt;
`ifdef ALU_MC_MUL_EN
            OP_MUL:  alu_ill = 1'b0;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

`ifdef ALU_MC_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;

    state_t             state;
    state_t             state_next;
    logic [SHAMT_W-1:0] cnt;
    logic [D_WIDTH-1:0] acc;
    logic [D_WIDTH-1:0] mcand;
    logic [D_WIDTH-1:0] mplier;
    logic [D_WIDTH-1:0] mul_sum;
    logic               mul_last;
    logic               mul_start;
    logic               mul_done;
    logic               mul_step;

    assign mul_sum   = acc + (mplier[0] ? mcand : '0);
    assign mul_last  = (cnt == SHAMT_W'(D_WIDTH - 1));
    assign mul_start = accept && (alu_op == OP_MUL);
    assign mul_done  = (state == MUL) && mul_last && out_free;
    // The final iteration freezes until the output register can take the product
    assign mul_step  = (state == MUL) && (!mul_last || out_free);
    assign in_ready  = (state == IDLE) && out_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (mul_start) state_next = MUL;
            MUL:     if (mul_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (mul_start) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (mul_step) begin
            cnt    <= cnt + 1'b1;
            acc    <= mul_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    always_comb begin
        wr_en  = (accept && !mul_start) || mul_done;
        wr_y   = alu_y;
        wr_c   = alu_c;
        wr_v   = alu_v;
        wr_ill = alu_ill;
        if (mul_done) begin
            wr_y   = mul_sum;
            wr_c   = 1'b0;
            wr_v   = 1'b0;
            wr_ill = 1'b0;
        end
    end
`else
    assign in_ready = out_free;

    always_comb begin
        wr_en  = accept;
        wr_y   = alu_y;
        wr_c   = alu_c;
        wr_v   = alu_v;
        wr_ill = alu_ill;
    end
`endif

    // Output register: loads on a new result, otherwise holds until taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            y         <= '0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
        end else if (wr_en) begin
            out_valid <= 1'b1;
            y         <= wr_y;
            zero      <= (wr_y == '0);
            neg       <= wr_y[MSB];
            carry     <= wr_c;
            ovf       <= wr_v;
            illegal   <= wr_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
